// File: rtl/cam_ctrl_pkg.sv
// Shared types for the CAM fill controller: FSM state encoding and statistics helpers.
package cam_ctrl_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MISS,
      FILL,
      RESP,
      FLUSH
   } state_t;

   // Saturating increment for the hit/miss statistics.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/cam_fill_ctrl_if.sv
// Bundle of requester, CAM and backing-memory signals around the fill controller.
interface cam_fill_ctrl_if
   import cam_ctrl_pkg::*;
#(
   parameter int WORDS     = 8,
   parameter int BITS      = 8,
   parameter int TAG_SZ    = 8,
   parameter int ADDR_LEFT = $clog2(WORDS)-1
);
   // Request handshake: a lookup is taken on any clock edge where req && ready;
   // req_tag is sampled on that edge, and the controller answers with exactly one
   // resp_valid strobe. Memory handshake: mem_req holds until the cycle mem_ack is
   // high, and mem_rdata is valid in that same cycle.
   logic                 req;
   logic [TAG_SZ-1:0]    req_tag;
   logic                 flush;
   logic                 ready;
   logic                 resp_valid;
   logic                 resp_hit;
   logic [BITS-1:0]      resp_data;

   logic                 cam_read;
   logic [TAG_SZ-1:0]    cam_check_tag;
   logic [BITS-1:0]      cam_data;
   logic                 cam_found_it;
   logic                 cam_write_;
   logic [ADDR_LEFT:0]   cam_w_addr;
   logic [BITS-1:0]      cam_wdata;
   logic [TAG_SZ-1:0]    cam_new_tag;
   logic                 cam_new_valid;

   logic                 mem_req;
   logic [TAG_SZ-1:0]    mem_tag;
   logic                 mem_ack;
   logic [BITS-1:0]      mem_rdata;

   logic [CNT_W-1:0]     hit_cnt;
   logic [CNT_W-1:0]     miss_cnt;

   modport master (
      input  req, req_tag, flush, cam_data, cam_found_it, mem_ack, mem_rdata,
      output ready, resp_valid, resp_hit, resp_data,
      output cam_read, cam_check_tag, cam_write_, cam_w_addr, cam_wdata,
      output cam_new_tag, cam_new_valid, mem_req, mem_tag, hit_cnt, miss_cnt
   );

   modport slave (
      output req, req_tag, flush, cam_data, cam_found_it, mem_ack, mem_rdata,
      input  ready, resp_valid, resp_hit, resp_data,
      input  cam_read, cam_check_tag, cam_write_, cam_w_addr, cam_wdata,
      input  cam_new_tag, cam_new_valid, mem_req, mem_tag, hit_cnt, miss_cnt
   );

endinterface

// File: rtl/cam_victim_ptr.sv
// Round-robin CAM index counter; wraps at WORDS, so WORDS need not be a power of two.
module cam_victim_ptr #(
   parameter int WORDS = 8,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic          i_inc,
   input  logic          i_clr,
   output logic [AW-1:0] o_ptr
);

   localparam logic [AW-1:0] LAST_IDX = AW'(WORDS-1);

   logic [AW-1:0] r_ptr;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_ptr <= '0;
      end else if (i_clr) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= (r_ptr == LAST_IDX) ? '0 : r_ptr + AW'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/cam_fill_ctrl.sv
// Lookup / miss-fetch / round-robin refill sequencer for the tag-matched CAM cache,
// with whole-cache flush and saturating hit/miss statistics.
module cam_fill_ctrl
   import cam_ctrl_pkg::*;
#(
   parameter int WORDS     = 8,
   parameter int BITS      = 8,
   parameter int TAG_SZ    = 8,
   parameter int ADDR_LEFT = $clog2(WORDS)-1
) (
   input  logic            clk,
   input  logic            rst_,
   cam_fill_ctrl_if.master bus,
   output state_t          o_dbg_state
);

   localparam int                 AW       = ADDR_LEFT + 1;
   localparam logic [ADDR_LEFT:0] LAST_IDX = AW'(WORDS-1);

   state_t             r_state;
   state_t             w_next;
   logic [TAG_SZ-1:0]  r_tag;
   logic [BITS-1:0]    r_fetch;
   logic               r_resp_hit;
   logic [BITS-1:0]    r_resp_data;
   logic [CNT_W-1:0]   r_hit_cnt;
   logic [CNT_W-1:0]   r_miss_cnt;
   logic               r_flush_pend;
   logic               w_vic_inc;
   logic               w_vic_clr;
   logic [ADDR_LEFT:0] w_victim;

   // The same pointer picks the refill victim and walks the indices during flush.
   cam_victim_ptr #(
      .WORDS (WORDS),
      .AW    (AW)
   ) u_victim (
      .clk   (clk),
      .rst_  (rst_),
      .i_inc (w_vic_inc),
      .i_clr (w_vic_clr),
      .o_ptr (w_victim)
   );

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_vic_inc = 1'b0;
      w_vic_clr = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.flush) begin
               w_next    = FLUSH;
               w_vic_clr = 1'b1;
            end else if (bus.req) begin
               w_next = LOOKUP;
            end
         end
         LOOKUP: w_next = bus.cam_found_it ? RESP : MISS;
         MISS: begin
            if (bus.mem_ack) w_next = FILL;
         end
         FILL: begin
            w_next    = RESP;
            w_vic_inc = 1'b1;
         end
         RESP: begin
            if (r_flush_pend || bus.flush) begin
               w_next    = FLUSH;
               w_vic_clr = 1'b1;
            end else begin
               w_next = IDLE;
            end
         end
         FLUSH: begin
            // Wrap on the last index leaves the pointer at 0 for the next refill.
            w_vic_inc = 1'b1;
            if (w_victim == LAST_IDX) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_tag        <= '0;
         r_fetch      <= '0;
         r_resp_hit   <= 1'b0;
         r_resp_data  <= '0;
         r_hit_cnt    <= '0;
         r_miss_cnt   <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         if (r_state == IDLE && bus.req && !bus.flush) r_tag <= bus.req_tag;
         if (r_state == MISS && bus.mem_ack) r_fetch <= bus.mem_rdata;
         // Response fields change only on entry to RESP so they hold between responses.
         if (r_state == LOOKUP && bus.cam_found_it) begin
            r_resp_hit  <= 1'b1;
            r_resp_data <= bus.cam_data;
         end
         if (r_state == FILL) begin
            r_resp_hit  <= 1'b0;
            r_resp_data <= r_fetch;
         end
         if (r_state == RESP) begin
            if (r_resp_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
            else            r_miss_cnt <= sat_inc(r_miss_cnt);
         end
         if (w_next == FLUSH) begin
            r_flush_pend <= 1'b0;
         end else if (bus.flush && r_state != IDLE && r_state != FLUSH) begin
            r_flush_pend <= 1'b1;
         end
      end
   end

   assign bus.ready         = (r_state == IDLE);
   assign bus.resp_valid    = (r_state == RESP);
   assign bus.resp_hit      = r_resp_hit;
   assign bus.resp_data     = r_resp_data;
   assign bus.cam_read      = (r_state == LOOKUP);
   assign bus.cam_check_tag = r_tag;
   assign bus.cam_write_    = !(r_state == FILL || r_state == FLUSH);
   assign bus.cam_w_addr    = w_victim;
   assign bus.cam_wdata     = (r_state == FILL) ? r_fetch : '0;
   assign bus.cam_new_tag   = (r_state == FILL) ? r_tag : '0;
   assign bus.cam_new_valid = (r_state == FILL);
   assign bus.mem_req       = (r_state == MISS);
   assign bus.mem_tag       = r_tag;
   assign bus.hit_cnt       = r_hit_cnt;
   assign bus.miss_cnt      = r_miss_cnt;
   assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_cam_fill_ctrl.sv
// Directed bench for cam_fill_ctrl with a behavioural 8-entry CAM beside it.
module tb_cam_fill_ctrl;
   import cam_ctrl_pkg::*;

   logic   clk;
   logic   rst_;
   state_t dbg_state;
   int     n_vec;
   int     n_err;

   cam_fill_ctrl_if #(.WORDS(8), .BITS(8), .TAG_SZ(8)) bus ();

   cam_fill_ctrl #(.WORDS(8), .BITS(8), .TAG_SZ(8)) dut (
      .clk         (clk),
      .rst_        (rst_),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural CAM: combinational match, write on the clock edge
   logic       m_v   [8];
   logic [7:0] m_tag [8];
   logic [7:0] m_dat [8];
   logic       cam_found;
   logic [7:0] cam_rd;

   always_comb begin
      cam_found = 1'b0;
      cam_rd    = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (bus.cam_read && m_v[i] && m_tag[i] == bus.cam_check_tag) begin
            cam_found = 1'b1;
            cam_rd    = m_dat[i];
         end
      end
   end

   assign bus.cam_found_it = cam_found;
   assign bus.cam_data     = cam_rd;

   always @(posedge clk) begin
      if (!rst_) begin
         for (int i = 0; i < 8; i++) m_v[i] <= 1'b0;
      end else if (!bus.cam_write_) begin
         m_v[bus.cam_w_addr]   <= bus.cam_new_valid;
         m_tag[bus.cam_w_addr] <= bus.cam_new_tag;
         m_dat[bus.cam_w_addr] <= bus.cam_wdata;
      end
   end

   // driver tasks
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_counts(input logic [15:0] hits, input logic [15:0] misses);
      chk("hit_cnt", 32'(bus.hit_cnt), 32'(hits));
      chk("miss_cnt", 32'(bus.miss_cnt), 32'(misses));
   endtask

   // Called in the first FLUSH cycle; optionally re-pulses flush at walk step pulse_at.
   task automatic flush_walk(input int pulse_at);
      for (int i = 0; i < 8; i++) begin
         chk("fl_state", 32'(dbg_state), 32'(FLUSH));
         chk("fl_ready", 32'(bus.ready), 32'd0);
         chk("fl_write_", 32'(bus.cam_write_), 32'd0);
         chk("fl_addr", 32'(bus.cam_w_addr), 32'(i));
         chk("fl_valid", 32'(bus.cam_new_valid), 32'd0);
         chk("fl_wdata", 32'(bus.cam_wdata), 32'd0);
         chk("fl_tag", 32'(bus.cam_new_tag), 32'd0);
         if (i == pulse_at) bus.flush = 1'b1;
         tick();
         bus.flush = 1'b0;
      end
      chk("fl_end_state", 32'(dbg_state), 32'(IDLE));
      chk("fl_end_ready", 32'(bus.ready), 32'd1);
      chk("fl_end_write_", 32'(bus.cam_write_), 32'd1);
   endtask

   task automatic lookup_hit(input logic [7:0] tag, input logic [7:0] data);
      chk("hit_idle_ready", 32'(bus.ready), 32'd1);
      bus.req     = 1'b1;
      bus.req_tag = tag;
      bus.mem_ack = 1'b1;
      tick();
      bus.req = 1'b0;
      chk("hit_lk_state", 32'(dbg_state), 32'(LOOKUP));
      chk("hit_cam_read", 32'(bus.cam_read), 32'd1);
      chk("hit_lk_tag", 32'(bus.cam_check_tag), 32'(tag));
      chk("hit_lk_ready", 32'(bus.ready), 32'd0);
      tick();
      chk("hit_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("hit_resp_hit", 32'(bus.resp_hit), 32'd1);
      chk("hit_resp_data", 32'(bus.resp_data), 32'(data));
      chk("hit_no_mem_req", 32'(bus.mem_req), 32'd0);
      tick();
      bus.mem_ack = 1'b0;
      chk("hit_back_idle", 32'(dbg_state), 32'(IDLE));
      chk("hit_valid_low", 32'(bus.resp_valid), 32'd0);
      chk("hit_data_hold", 32'(bus.resp_data), 32'(data));
   endtask

   task automatic lookup_miss(input logic [7:0] tag, input int k, input logic [7:0] rdata,
                              input logic [2:0] widx, input int flush_at, input bit exp_flush);
      chk("ms_idle_ready", 32'(bus.ready), 32'd1);
      bus.req     = 1'b1;
      bus.req_tag = tag;
      tick();
      bus.req = 1'b0;
      chk("ms_lk_state", 32'(dbg_state), 32'(LOOKUP));
      chk("ms_lk_tag", 32'(bus.cam_check_tag), 32'(tag));
      tick();
      for (int c = 0; c <= k; c++) begin
         chk("ms_mem_req", 32'(bus.mem_req), 32'd1);
         chk("ms_mem_tag", 32'(bus.mem_tag), 32'(tag));
         chk("ms_cam_write_", 32'(bus.cam_write_), 32'd1);
         if (c == flush_at) bus.flush = 1'b1;
         if (c == k) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rdata;
         end
         tick();
         bus.flush     = 1'b0;
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = 8'h00;
      end
      chk("fill_state", 32'(dbg_state), 32'(FILL));
      chk("fill_mem_req", 32'(bus.mem_req), 32'd0);
      chk("fill_write_", 32'(bus.cam_write_), 32'd0);
      chk("fill_addr", 32'(bus.cam_w_addr), 32'(widx));
      chk("fill_wdata", 32'(bus.cam_wdata), 32'(rdata));
      chk("fill_tag", 32'(bus.cam_new_tag), 32'(tag));
      chk("fill_valid", 32'(bus.cam_new_valid), 32'd1);
      chk("fill_resp_valid", 32'(bus.resp_valid), 32'd0);
      tick();
      chk("ms_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("ms_resp_hit", 32'(bus.resp_hit), 32'd0);
      chk("ms_resp_data", 32'(bus.resp_data), 32'(rdata));
      tick();
      if (exp_flush) begin
         flush_walk(-1);
      end else begin
         chk("ms_back_idle", 32'(dbg_state), 32'(IDLE));
         chk("ms_ready", 32'(bus.ready), 32'd1);
         chk("ms_valid_low", 32'(bus.resp_valid), 32'd0);
         chk("ms_data_hold", 32'(bus.resp_data), 32'(rdata));
      end
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      rst_          = 1'b0;
      bus.req       = 1'b0;
      bus.req_tag   = 8'h00;
      bus.flush     = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 8'h00;
      tick();
      tick();

      // reset state
      chk("rst_state", 32'(dbg_state), 32'(IDLE));
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
      chk("rst_cam_read", 32'(bus.cam_read), 32'd0);
      chk("rst_cam_write_", 32'(bus.cam_write_), 32'd1);
      chk("rst_w_addr", 32'(bus.cam_w_addr), 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk_counts(16'd0, 16'd0);
      rst_ = 1'b1;
      tick();

      // miss then hit on the same tag
      lookup_miss(8'h3C, 1, 8'hA5, 3'd0, -1, 1'b0);
      chk_counts(16'd0, 16'd1);
      lookup_hit(8'h3C, 8'hA5);
      chk_counts(16'd1, 16'd1);

      // memory stall of five cycles, then an ack in the same cycle mem_req rises
      lookup_miss(8'h11, 5, 8'h5A, 3'd1, -1, 1'b0);
      lookup_miss(8'h22, 0, 8'h77, 3'd2, -1, 1'b0);

      // victim wrap: misses 4..9 fill indices 3..7 then 0
      lookup_miss(8'h40, 2, 8'hC0, 3'd3, -1, 1'b0);
      lookup_miss(8'h41, 0, 8'hC1, 3'd4, -1, 1'b0);
      lookup_miss(8'h42, 1, 8'hC2, 3'd5, -1, 1'b0);
      lookup_miss(8'h43, 0, 8'hC3, 3'd6, -1, 1'b0);
      lookup_miss(8'h44, 3, 8'hC4, 3'd7, -1, 1'b0);
      lookup_miss(8'h45, 0, 8'hC5, 3'd0, -1, 1'b0);
      lookup_miss(8'h3C, 1, 8'hA6, 3'd1, -1, 1'b0);
      lookup_hit(8'h22, 8'h77);
      chk_counts(16'd2, 16'd10);

      // flush with a simultaneous request; a second flush mid-walk is absorbed
      bus.flush   = 1'b1;
      bus.req     = 1'b1;
      bus.req_tag = 8'h22;
      tick();
      bus.flush = 1'b0;
      bus.req   = 1'b0;
      flush_walk(3);
      tick();
      chk("fl_absorbed", 32'(dbg_state), 32'(IDLE));
      lookup_miss(8'h22, 0, 8'h99, 3'd0, -1, 1'b0);

      // flush pulse during MISS is deferred until after the response
      lookup_miss(8'h50, 3, 8'h31, 3'd1, 1, 1'b1);
      lookup_miss(8'h50, 0, 8'h32, 3'd0, -1, 1'b0);
      chk_counts(16'd2, 16'd13);

      // reset in the middle of a miss
      bus.req     = 1'b1;
      bus.req_tag = 8'h60;
      tick();
      bus.req = 1'b0;
      tick();
      chk("rm_mem_req", 32'(bus.mem_req), 32'd1);
      #2;
      rst_ = 1'b0;
      #1;
      chk("rm_mem_req_drop", 32'(bus.mem_req), 32'd0);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'hEE;
      tick();
      chk("rm_state", 32'(dbg_state), 32'(IDLE));
      chk("rm_ready", 32'(bus.ready), 32'd1);
      chk_counts(16'd0, 16'd0);
      rst_ = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      chk("rm_after_state", 32'(dbg_state), 32'(IDLE));
      chk("rm_after_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rm_after_write_", 32'(bus.cam_write_), 32'd1);
      chk("rm_after_resp", 32'(bus.resp_valid), 32'd0);

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cam_fill_ctrl.md
# cam_fill_ctrl

Sequencing controller for the tag-matched CAM cache. Accepts one lookup request at a time and drives the CAM lookup. On a miss it fetches the word from the backing memory over a req/ack handshake, then refills a CAM entry chosen round-robin and returns the data. Also provides a whole-cache flush that clears every valid bit, and hit/miss statistics counters. Sits between the requesting pipeline stage and the CAM/memory pair.

## Interface
- WORDS, 8, CAM entries; any value ≥2, need not be a power of two
- BITS, 8, data word width
- TAG_SZ, 8, tag width
- ADDR_LEFT, $clog2(WORDS)-1, MSB of the CAM entry index
- clk  in  1  system clock
- rst_  in  1  reset, asynchronous, active-low
- req  in  1  lookup request; accepted only when ready=1
- req_tag  in  TAG_SZ  tag to look up; sampled on acceptance
- flush  in  1  one-cycle pulse; invalidate all entries
- ready  out  1  controller idle, request may be accepted
- resp_valid  out  1  one-cycle response strobe
- resp_hit  out  1  response was a CAM hit
- resp_data  out  BITS  response data
- cam_read  out  1  CAM lookup enable
- cam_check_tag  out  TAG_SZ  tag presented to the CAM
- cam_data  in  BITS  CAM match data (combinational from the CAM)
- cam_found_it  in  1  CAM match flag (combinational from the CAM)
- cam_write_  out  1  CAM write strobe, active-low
- cam_w_addr  out  ADDR_LEFT+1  CAM write index
- cam_wdata  out  BITS  CAM write data
- cam_new_tag  out  TAG_SZ  CAM write tag
- cam_new_valid  out  1  CAM write valid bit
- mem_req  out  1  backing-memory read request
- mem_tag  out  TAG_SZ  tag being fetched
- mem_ack  in  1  memory read complete; mem_rdata valid this cycle
- mem_rdata  in  BITS  memory read data
- hit_cnt, miss_cnt  out  16 each  saturating statistics counters

## Operation
- States:
  - IDLE: ready=1.
  - LOOKUP: cam_read=1, cam_check_tag=tag_q.
    - Found → capture cam_data, go to RESP with hit=1.
    - Not found → MISS.
  - MISS: mem_req=1, mem_tag=tag_q, held until mem_ack. On the ack cycle capture mem_rdata, then go to FILL.
  - FILL: cam_write_=0, cam_w_addr=victim, cam_wdata=fetched data, cam_new_tag=tag_q, cam_new_valid=1. Victim advances; go to RESP with hit=0.
  - RESP: resp_valid=1 for one cycle, then IDLE or FLUSH.
  - FLUSH: see flush bullet below.
- In IDLE, req && ready loads tag_q and moves to LOOKUP.
- Victim pointer: reset 0. Increments once per FILL; WORDS-1 wraps to 0. Flush resets it to 0.
- Flush:
  - In IDLE, flush has priority over a simultaneous req. The req is not accepted; the requester retries.
  - FLUSH writes cam_new_valid=0, cam_wdata=0, cam_new_tag=0 to indices 0..WORDS-1, one per cycle, then returns to IDLE.
  - A flush pulse arriving outside IDLE sets flush_pend. After RESP the controller goes to FLUSH instead of IDLE. A flush during FLUSH is absorbed.
- Counters: hit_cnt increments on every RESP with hit=1, miss_cnt on every RESP with hit=0. Both saturate at 16'hFFFF and clear only on reset.
- Default outputs outside their state: cam_read=0, cam_write_=1, mem_req=0, resp_valid=0.
- resp_hit and resp_data are registered; they hold their value until the next RESP.

## Timing
- Reset: state=IDLE, ready=1, and all of the following are 0: resp_valid, resp_hit, resp_data, cam_read, cam_check_tag, cam_w_addr, cam_wdata, cam_new_tag, cam_new_valid, mem_req, mem_tag, hit_cnt, miss_cnt, victim, flush_pend. cam_write_=1.
- Reset mid-operation aborts immediately: mem_req drops asynchronously and any outstanding mem_ack is ignored.
- Hit: request accepted at edge 0; resp_valid high in cycle 2. Throughput is one request per 3 cycles.
- Miss: mem_req rises in cycle 2. With mem_ack in cycle 2+k, FILL is in cycle 3+k and resp_valid in cycle 4+k.
- mem_ack asserted in the same cycle mem_req rises is legal (k=0). mem_ack outside MISS is ignored.
- The refilled entry is visible to a lookup starting in the cycle after FILL.
- Flush occupies exactly WORDS cycles. ready=0 throughout, and ready returns to 1 in the cycle after the last write.

## Structure
- Shared package cam_ctrl_pkg:
  - state enum: IDLE, LOOKUP, MISS, FILL, RESP, FLUSH
  - counter width constant CNT_W=16
- Optional sub-module cam_victim_ptr: wrap-at-WORDS counter with inc and clr inputs. FLUSH reuses it as its index counter.

## Test plan
- Hit after fill: miss on tag 8'h3C with mem_rdata 8'hA5 → resp_hit=0, resp_data=A5, CAM write at index 0. A repeat lookup of 3C → resp_hit=1, data A5, resp_valid 2 cycles after acceptance, hit_cnt=1, miss_cnt=1.
- Memory stall: mem_ack delayed 5 cycles → mem_req held for exactly 6 cycles, resp_valid in cycle 9 after acceptance.
- Victim wrap (WORDS=8): 9 distinct misses → writes at indices 0..7 then 0. The first tag now misses.
- Flush priority: flush and req in the same IDLE cycle → 8 invalidate writes at indices 0..7, the req is not accepted, ready=0 for 8 cycles. A lookup of a previously cached tag then misses.
- Pending flush: flush pulse during MISS → the response completes, then FLUSH starts the cycle after RESP.
- Reset mid-miss: rst_ low while mem_req=1 → mem_req=0 immediately. After release: IDLE, ready=1, counters 0.
